// File: rtl/snoop_cache_ctrl.sv
// Direct-mapped write-back MSI cache between one CPU and a shared snooping bus.
// Evicts dirty victims, fills over a request/grant bus and snoops peers to flush or invalidate lines.
module snoop_cache_ctrl #(
    parameter  int ADDRESSBIT    = 16,
    parameter  int WORDSIZE      = 8,
    parameter  int BLOCKWORDS    = 4,
    parameter  int CACHELINENUM  = 8,
    localparam int OFFSETADDRBIT = $clog2(BLOCKWORDS),
    localparam int BLOCKADDRBIT  = ADDRESSBIT - OFFSETADDRBIT,
    localparam int LINEBITS      = BLOCKWORDS * WORDSIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpuReq,
    input  logic                    cpuRW,
    input  logic [ADDRESSBIT-1:0]   cpuAddr,
    input  logic [WORDSIZE-1:0]     cpuDataIn,
    output logic [WORDSIZE-1:0]     cpuDataOut,
    output logic                    cpuSuccess,
    output logic                    errToCpu,
    output logic                    busReq,
    input  logic                    busGnt,
    output logic [2:0]              busCmd,
    output logic [BLOCKADDRBIT-1:0] busAddr,
    output logic [LINEBITS-1:0]     busDataOut,
    input  logic [LINEBITS-1:0]     busDataIn,
    input  logic                    busDone,
    input  logic                    errFromBus,
    input  logic                    snoopValid,
    input  logic [2:0]              snoopCmd,
    input  logic [BLOCKADDRBIT-1:0] snoopAddr,
    output logic                    snoopFlush
);
    localparam int INDEXBIT = $clog2(CACHELINENUM);
    localparam int TAGBIT   = BLOCKADDRBIT - INDEXBIT;

    localparam logic [2:0] CMD_NONE = 3'd0, CMD_RD = 3'd1, CMD_RDX = 3'd2,
                           CMD_UPGR = 3'd3, CMD_WB = 3'd4;

    typedef enum logic [1:0] {LI, LS, LM} line_st_t;
    typedef enum logic [2:0] {IDLE, WB, FILL, UPG, RESP} fsm_t;

    line_st_t            line_state [CACHELINENUM];
    logic [TAGBIT-1:0]   line_tag   [CACHELINENUM];
    logic [LINEBITS-1:0] line_data  [CACHELINENUM];

    fsm_t                state, next;
    logic [WORDSIZE-1:0] resp_data, resp_d;
    logic                resp_err, resp_e, set_resp;
    logic                flush_q, wb_done_q;
    logic [LINEBITS-1:0] flush_data, fill_line;
    logic                do_merge, do_upg, do_wb_done, do_install, gnt;
    logic [2:0]          cmd;

    logic [BLOCKADDRBIT-1:0]  blk;
    logic [INDEXBIT-1:0]      idx, s_idx;
    logic [TAGBIT-1:0]        tag, s_tag;
    logic [OFFSETADDRBIT-1:0] off;
    line_st_t                 cur_st, s_st;
    logic                     hit, s_hit, s_inv, s_flush, s_conflict;
    logic [WORDSIZE-1:0]      cur_word;

    assign blk      = cpuAddr[ADDRESSBIT-1:OFFSETADDRBIT];
    assign idx      = blk[INDEXBIT-1:0];
    assign tag      = blk[BLOCKADDRBIT-1:INDEXBIT];
    assign off      = cpuAddr[OFFSETADDRBIT-1:0];
    assign cur_st   = line_state[idx];
    assign hit      = (cur_st != LI) && (line_tag[idx] == tag);
    assign cur_word = line_data[idx][off*WORDSIZE +: WORDSIZE];

    assign s_idx   = snoopAddr[INDEXBIT-1:0];
    assign s_tag   = snoopAddr[BLOCKADDRBIT-1:INDEXBIT];
    assign s_st    = line_state[s_idx];
    assign s_hit   = snoopValid && (s_st != LI) && (line_tag[s_idx] == s_tag);
    assign s_inv   = (snoopCmd == CMD_RDX) || (snoopCmd == CMD_UPGR);
    assign s_flush = s_hit && (s_st == LM) && (s_inv || snoopCmd == CMD_RD);
    // A snoop that changes the CPU's own line makes the CPU wait a cycle and re-evaluate.
    assign s_conflict = (s_flush || (s_hit && s_inv)) && (s_idx == idx);

    // One idle cycle of busReq after a writeback lets the arbiter re-arbitrate before the fill.
    assign busReq = ((state == WB) || (state == FILL) || (state == UPG)) && !wb_done_q;
    assign gnt    = busGnt && busReq;

    always_comb begin
        fill_line = busDataIn;
        if (cpuRW) fill_line[off*WORDSIZE +: WORDSIZE] = cpuDataIn;
    end

    always_comb begin
        next       = state;
        cmd        = CMD_NONE;
        do_merge   = 1'b0;
        do_upg     = 1'b0;
        do_wb_done = 1'b0;
        do_install = 1'b0;
        set_resp   = 1'b0;
        resp_d     = '0;
        resp_e     = 1'b0;
        case (state)
            IDLE: if (cpuReq && !s_conflict) begin
                if (hit) begin
                    if (!cpuRW) begin
                        next = RESP; set_resp = 1'b1; resp_d = cur_word;
                    end else if (cur_st == LM) begin
                        next = RESP; set_resp = 1'b1; resp_d = cpuDataIn; do_merge = 1'b1;
                    end else begin
                        next = UPG;
                    end
                end else if (cur_st == LM) begin
                    next = WB;
                end else begin
                    next = FILL;
                end
            end
            WB: if (gnt) begin
                cmd = CMD_WB;
                if (busDone) begin
                    if (errFromBus) begin
                        next = RESP; set_resp = 1'b1; resp_e = 1'b1;
                    end else begin
                        next = FILL; do_wb_done = 1'b1;
                    end
                end
            end else if (cur_st != LM) begin
                next = FILL;  // victim already flushed by a peer snoop
            end
            FILL: if (gnt) begin
                cmd = cpuRW ? CMD_RDX : CMD_RD;
                if (busDone) begin
                    next = RESP; set_resp = 1'b1;
                    if (errFromBus) resp_e = 1'b1;
                    else begin
                        do_install = 1'b1;
                        resp_d     = cpuRW ? cpuDataIn : busDataIn[off*WORDSIZE +: WORDSIZE];
                    end
                end
            end
            UPG: if (!hit) begin
                next = FILL;  // lost the shared copy, need exclusive fill instead
            end else if (gnt) begin
                cmd = CMD_UPGR;
                if (busDone) begin
                    next = RESP; set_resp = 1'b1;
                    if (errFromBus) resp_e = 1'b1;
                    else begin
                        do_upg = 1'b1; resp_d = cpuDataIn;
                    end
                end
            end
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data  <= '0;
            resp_err   <= 1'b0;
            flush_q    <= 1'b0;
            flush_data <= '0;
            wb_done_q  <= 1'b0;
            for (int i = 0; i < CACHELINENUM; i++) begin
                line_state[i] <= LI;
                line_tag[i]   <= '0;
                line_data[i]  <= '0;
            end
        end else begin
            wb_done_q <= do_wb_done;
            flush_q   <= s_flush;
            if (s_flush) flush_data <= line_data[s_idx];
            if (set_resp) begin
                resp_data <= resp_d;
                resp_err  <= resp_e;
            end
            // Snoop first: CPU updates below only touch lines a snoop is not changing.
            if (s_hit && s_inv) line_state[s_idx] <= LI;
            else if (s_flush)   line_state[s_idx] <= LS;
            if (do_merge || do_upg) line_data[idx][off*WORDSIZE +: WORDSIZE] <= cpuDataIn;
            if (do_upg)     line_state[idx] <= LM;
            if (do_wb_done) line_state[idx] <= LI;
            if (do_install) begin
                line_state[idx] <= cpuRW ? LM : LS;
                line_tag[idx]   <= tag;
                line_data[idx]  <= fill_line;
            end
        end
    end

    assign cpuSuccess = (state == RESP);
    assign cpuDataOut = (state == RESP) ? resp_data : '0;
    assign errToCpu   = (state == RESP) && resp_err;
    assign busCmd     = cmd;
    assign busAddr    = (cmd == CMD_NONE) ? '0 : ((state == WB) ? {line_tag[idx], idx} : blk);
    assign busDataOut = (state == WB && gnt) ? line_data[idx] : (flush_q ? flush_data : '0);
    assign snoopFlush = flush_q;

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Directed bench for snoop_cache_ctrl: the bench plays CPU, arbiter/memory and peer snooper.
module tb_snoop_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset, cpuReq, cpuRW, cpuSuccess, errToCpu;
    logic [15:0] cpuAddr;
    logic [7:0]  cpuDataIn, cpuDataOut;
    logic        busReq, busGnt, busDone, errFromBus, snoopValid, snoopFlush;
    logic [2:0]  busCmd, snoopCmd;
    logic [13:0] busAddr, snoopAddr;
    logic [31:0] busDataOut, busDataIn;
    int          vectors, miscompares;

    snoop_cache_ctrl dut (
        .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuRW(cpuRW), .cpuAddr(cpuAddr),
        .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuSuccess(cpuSuccess),
        .errToCpu(errToCpu), .busReq(busReq), .busGnt(busGnt), .busCmd(busCmd),
        .busAddr(busAddr), .busDataOut(busDataOut), .busDataIn(busDataIn),
        .busDone(busDone), .errFromBus(errFromBus), .snoopValid(snoopValid),
        .snoopCmd(snoopCmd), .snoopAddr(snoopAddr), .snoopFlush(snoopFlush)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; cpuReq = 1'b0; cpuRW = 1'b0; cpuAddr = '0; cpuDataIn = '0;
        busGnt = 1'b0; busDone = 1'b0; errFromBus = 1'b0; busDataIn = '0;
        snoopValid = 1'b0; snoopCmd = '0; snoopAddr = '0;
        repeat (2) cyc();
        chk("rst_busReq", busReq, 0);
        chk("rst_success", cpuSuccess, 0);
        chk("rst_busCmd", busCmd, 0);
        chk("rst_flush", snoopFlush, 0);
        reset = 1'b1; cyc();

        // read miss -> BUSRD fill, line S
        cpuReq = 1; cpuRW = 0; cpuAddr = 16'h0010; cyc();
        chk("t1_req", busReq, 1);
        chk("t1_nognt_cmd", busCmd, 0);
        busGnt = 1; #1;
        chk("t1_cmd", busCmd, 1);
        chk("t1_addr", busAddr, 14'h0004);
        busDataIn = 32'h44332211; busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t1_succ", cpuSuccess, 1);
        chk("t1_data", cpuDataOut, 8'h11);
        chk("t1_err", errToCpu, 0);
        chk("t1_reqdrop", busReq, 0);
        cpuReq = 0; cyc();
        chk("t1_idle", cpuSuccess, 0);

        // read hit, 1-cycle latency, no bus
        cpuReq = 1; cpuAddr = 16'h0013; cyc();
        chk("hit_succ", cpuSuccess, 1);
        chk("hit_data", cpuDataOut, 8'h44);
        chk("hit_nobus", busReq, 0);
        cpuReq = 0; cyc();

        // write hit S -> BUSUPGR, then read back from M line
        cpuReq = 1; cpuRW = 1; cpuAddr = 16'h0011; cpuDataIn = 8'hAA; cyc();
        chk("t2_req", busReq, 1);
        busGnt = 1; #1;
        chk("t2_cmd", busCmd, 3);
        busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t2_succ", cpuSuccess, 1);
        cpuReq = 0; cyc();
        cpuReq = 1; cpuRW = 0; #1;
        chk("t2_rd_nobus", busReq, 0);
        cyc();
        chk("t2_rd_succ", cpuSuccess, 1);
        chk("t2_rd_data", cpuDataOut, 8'hAA);
        cpuReq = 0; cyc();

        // conflicting read with dirty victim -> WB, gap, BUSRD
        cpuReq = 1; cpuAddr = 16'h0030; cyc();
        chk("t3_req", busReq, 1);
        busGnt = 1; #1;
        chk("t3_wb_cmd", busCmd, 4);
        chk("t3_wb_addr", busAddr, 14'h0004);
        chk("t3_wb_data", busDataOut, 32'h4433AA11);
        busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t3_gap", busReq, 0);
        cyc();
        chk("t3_rereq", busReq, 1);
        busGnt = 1; #1;
        chk("t3_rd_cmd", busCmd, 1);
        chk("t3_rd_addr", busAddr, 14'h000C);
        busDataIn = 32'h88776655; busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t3_data", cpuDataOut, 8'h55);
        cpuReq = 0; cyc();

        // make line M, then peer BUSRD -> flush + S, peer BUSRDX -> I without flush
        cpuReq = 1; cpuRW = 1; cpuAddr = 16'h0031; cpuDataIn = 8'hBB; cyc();
        busGnt = 1; busDone = 1; cyc();
        busGnt = 0; busDone = 0; cpuReq = 0; cyc();
        snoopValid = 1; snoopCmd = 3'd1; snoopAddr = 14'h000C; cyc();
        snoopValid = 0; #1;
        chk("t4_flush", snoopFlush, 1);
        chk("t4_flush_data", busDataOut, 32'h8877BB55);
        cyc();
        chk("t4_pulse", snoopFlush, 0);
        snoopValid = 1; snoopCmd = 3'd2; cyc();
        snoopValid = 0; #1;
        chk("t4_s_noflush", snoopFlush, 0);
        cpuReq = 1; cpuRW = 0; cpuAddr = 16'h0030; cyc();
        busGnt = 1; #1;
        chk("t4_inv_refill", busCmd, 1);
        busDataIn = 32'h04030201; busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t4_refill_data", cpuDataOut, 8'h01);
        cpuReq = 0; cyc();

        // write hit S, peer BUSRDX before grant -> own BUSRDX
        cpuReq = 1; cpuRW = 1; cpuAddr = 16'h0032; cpuDataIn = 8'hCC; cyc();
        snoopValid = 1; snoopCmd = 3'd2; snoopAddr = 14'h000C; cyc();
        snoopValid = 0; #1;
        chk("t5_wait_cmd", busCmd, 0);
        cyc();
        busGnt = 1; #1;
        chk("t5_cmd", busCmd, 2);
        busDataIn = 32'h0D0C0B0A; busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t5_succ", cpuSuccess, 1);
        cpuReq = 0; cyc();
        cpuReq = 1; cpuRW = 0; cyc();
        chk("t5_merge", cpuDataOut, 8'hCC);
        cpuReq = 0; cyc();

        // bus error on fill -> errToCpu, line stays invalid
        cpuReq = 1; cpuAddr = 16'h0000; cyc();
        busGnt = 1; busDone = 1; errFromBus = 1; cyc();
        busDone = 0; busGnt = 0; errFromBus = 0; #1;
        chk("t6_succ", cpuSuccess, 1);
        chk("t6_err", errToCpu, 1);
        cpuReq = 0; cyc();
        cpuReq = 1; cyc();
        chk("t6_still_miss", busReq, 1);
        busGnt = 1; busDataIn = 32'h11111111; busDone = 1; cyc();
        busDone = 0; busGnt = 0; #1;
        chk("t6_retry_data", cpuDataOut, 8'h11);
        chk("t6_retry_err", errToCpu, 0);
        cpuReq = 0; cyc();

        // reset in the middle of a granted writeback
        cpuReq = 1; cpuAddr = 16'h0050; cyc();
        busGnt = 1; #1;
        chk("t6_wb_cmd", busCmd, 4);
        chk("t6_wb_data", busDataOut, 32'h0DCC0B0A);
        reset = 0; #1;
        chk("t6_rst_req", busReq, 0);
        chk("t6_rst_cmd", busCmd, 0);
        cpuReq = 0; busGnt = 0; cyc();
        reset = 1; cyc();
        chk("t6_post_rst", cpuSuccess, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
